// File: rtl/producto_bcd.sv
// Sequential double-dabble: captures the multiplier's binary product on start
// and produces packed BCD one bit per clock, signalling completion with done.
module producto_bcd #(
    parameter int IN_W   = 17,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       producto_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [1:0]            estado
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    shift;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_next;

    // Every nibble >= 5 gets +3 so the following left shift carries into the next digit.
    function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int d = 0; d < DIGITS; d++) begin
            if (a[4*d +: 4] >= 4'd5)
                r[4*d +: 4] = a[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        acc_adj  = add3_digits(acc);
        acc_next = {acc_adj[ACC_W-2:0], shift[IN_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            acc     <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift <= producto_in;
                        acc   <= '0;
                        cnt   <= CNT_W'(IN_W);
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    shift <= {shift[IN_W-2:0], 1'b0};
                    cnt   <= cnt - CNT_W'(1);
                    // Last bit shifted in: publish the result and leave CONV before cnt can hit 0.
                    if (cnt == CNT_W'(1)) begin
                        bcd_out <= acc_next;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == CONV);
    assign done   = (state == DONE);
    assign estado = state;

endmodule
